button_event: RTL
=================

BUTTON_EVENT -- requirements
Module: button_event

Interface
REQ-001 SHALL have parameter PRESSED_LEVEL, default 1'b0, meaning the i_signal level that means "pressed" (board keys are active-low).
REQ-002 SHALL have parameter LONG_CYCLES, default 25_000_000, meaning the hold time in clocks before a long press (0.5 s at 50 MHz); legal range 2..2^24-1.
REQ-003 SHALL have parameter DOUBLE_CYCLES, default 12_500_000, meaning the maximum release-to-press gap in clocks for a double click; legal range 2..2^24-1.
REQ-004 SHALL have port i_sys_clk  input  1  system clock; all logic is on its rising edge.
REQ-005 SHALL have port i_rst  input  1  reset, asynchronous and active-high.
REQ-006 SHALL have port i_signal  input  1  debounced, already-synchronous button level from the debounce stage.
REQ-007 SHALL have ports o_press, o_release, o_click, o_double, o_long  output  1 each  single-cycle event pulses.
REQ-008 SHALL have port o_click_cnt  output  8  running count of o_click pulses.

Function
REQ-009 SHALL register i_signal into prev_lvl; press edge = (i_signal==PRESSED_LEVEL) && (prev_lvl!=PRESSED_LEVEL); release edge is the converse.
REQ-010 SHALL register all outputs; each pulse SHALL be high for exactly one cycle, asserted on the clock after the edge at which the causing condition is detected.
REQ-011 SHALL implement the FSM states IDLE, PRESS, HELD, GAP and PRESS2, with a 24-bit timer.
REQ-012 In IDLE, a press edge SHALL pulse o_press, clear the timer and enter PRESS.
REQ-013 In PRESS, the timer SHALL increment each cycle; when the timer reaches LONG_CYCLES-1 while still pressed, the block SHALL pulse o_long and enter HELD.
REQ-014 In PRESS, a release edge before the long threshold SHALL pulse o_release, clear the timer and enter GAP.
REQ-015 In HELD, a release edge SHALL pulse o_release and enter IDLE; no o_click SHALL be issued.
REQ-016 In GAP, a press edge while the timer is below DOUBLE_CYCLES-1 SHALL pulse o_press and o_double (same cycle) and enter PRESS2.
REQ-017 In GAP, when the timer reaches DOUBLE_CYCLES-1 with no press, the block SHALL pulse o_click, increment o_click_cnt and enter IDLE.
REQ-018 If the GAP press edge and the timer reaching DOUBLE_CYCLES-1 occur in the same cycle, the press SHALL win: o_double is issued and o_click is not.
REQ-019 In PRESS2, a release edge SHALL pulse o_release and enter IDLE; a long hold in PRESS2 SHALL NOT produce o_long.
REQ-020 o_click_cnt SHALL wrap from 255 to 0.
REQ-021 The timer SHALL saturate and never wrap.
REQ-022 Release edges in IDLE and press edges in PRESS, HELD and PRESS2 are impossible by construction; if they occur, the block SHALL ignore them without pulses or state change.

Reset
REQ-023 Asserting i_rst SHALL immediately force IDLE, timer=0, all pulse outputs=0 and o_click_cnt=0.
REQ-024 Asserting i_rst SHALL immediately force prev_lvl to the non-pressed level (~PRESSED_LEVEL).
REQ-025 Reset mid-press SHALL discard the press; if i_signal is still pressed after deassertion, the first clock SHALL be treated as a new press edge.

Configuration
REQ-026 Macro BUTTON_DOUBLE_CLICK_EN defined: the block SHALL behave per REQ-011..REQ-019.
REQ-027 Macro BUTTON_DOUBLE_CLICK_EN undefined: GAP and PRESS2 SHALL not exist and o_double SHALL be tied 0.
REQ-028 With BUTTON_DOUBLE_CLICK_EN undefined, a short release in PRESS SHALL pulse o_release and o_click in the same cycle, increment o_click_cnt and enter IDLE.

Verification (LONG_CYCLES=20, DOUBLE_CYCLES=10, PRESSED_LEVEL=0, macro defined unless stated)
REQ-029 Single click: hold i_signal low 5 clocks, then high -> one o_press and one o_release; o_click exactly 10 clocks after o_release; o_click_cnt 0->1.
REQ-030 Double click: low 5, high 4, low 5, high -> o_double together with the second o_press; no o_click; o_click_cnt unchanged.
REQ-031 Long press: low 30 clocks -> o_long exactly 20 clocks after o_press; on release one o_release; no o_click.
REQ-032 Macro undefined, low 5 then high -> o_release and o_click in the same cycle; o_double stays 0 throughout the test.
REQ-033 Wrap and reset: issue 256 single clicks -> o_click_cnt returns to 0; assert i_rst mid-press for 3 clocks with i_signal held low -> all outputs 0, then a fresh o_press on the first clock after deassertion.

Source files
------------

// File: rtl/button_event.sv
// Purpose: turns a debounced button level into press/release/click/double/long event pulses.
// Latency: every pulse is registered, high for one cycle after the edge that detects its cause.
// Backpressure: none; pulses are fire-and-forget. BUTTON_DOUBLE_CLICK_EN enables double-click.
//
// With BUTTON_DOUBLE_CLICK_EN undefined the GAP/PRESS2 states do not exist, a short
// release reports the click immediately and o_double is tied low.
module button_event #(
  parameter logic PRESSED_LEVEL = 1'b0,
  parameter int   LONG_CYCLES   = 25_000_000,
  parameter int   DOUBLE_CYCLES = 12_500_000
) (
  input  logic       i_sys_clk,
  input  logic       i_rst,
  input  logic       i_signal,
  output logic       o_press,
  output logic       o_release,
  output logic       o_click,
  output logic       o_double,
  output logic       o_long,
  output logic [7:0] o_click_cnt
);

  localparam logic [23:0] TIMER_MAX = 24'hFF_FFFF;
  // Compare against N-1: the timer reads 0 on the first cycle after entry.
  localparam logic [23:0] LONG_LAST = 24'(LONG_CYCLES - 1);

`ifdef BUTTON_DOUBLE_CLICK_EN
  localparam logic [23:0] DOUBLE_LAST = 24'(DOUBLE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRESS  = 3'd1,
    HELD   = 3'd2,
    GAP    = 3'd3,
    PRESS2 = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PRESS = 3'd1,
    HELD  = 3'd2
  } state_t;

  // The gap length only matters when double-click detection is built in.
  logic unused_double_cycles;
  assign unused_double_cycles = (DOUBLE_CYCLES != 0);
`endif

  state_t      state;
  state_t      state_nxt;
  logic [23:0] timer;
  logic [23:0] timer_nxt;
  logic [23:0] timer_inc;
  logic        prev_lvl;

  logic        press_nxt;
  logic        release_nxt;
  logic        click_nxt;
  logic        double_nxt;
  logic        long_nxt;
  logic [7:0]  click_cnt_nxt;

  logic        pressed;
  logic        press_edge;
  logic        release_edge;

  assign pressed      = (i_signal == PRESSED_LEVEL);
  assign press_edge   = pressed && (prev_lvl != PRESSED_LEVEL);
  assign release_edge = !pressed && (prev_lvl == PRESSED_LEVEL);

  // Saturating increment so a very long hold can never wrap back into a threshold.
  assign timer_inc = (timer == TIMER_MAX) ? timer : timer + 24'd1;

  // Previous level; reset to "not pressed" so a key held through reset is seen as a fresh press.
  always_ff @(posedge i_sys_clk or posedge i_rst) begin
    if (i_rst) begin
      prev_lvl <= ~PRESSED_LEVEL;
    end else begin
      prev_lvl <= i_signal;
    end
  end

  // State, timer and registered event outputs.
  always_ff @(posedge i_sys_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= IDLE;
      timer       <= '0;
      o_press     <= 1'b0;
      o_release   <= 1'b0;
      o_click     <= 1'b0;
      o_long      <= 1'b0;
      o_click_cnt <= '0;
    end else begin
      state       <= state_nxt;
      timer       <= timer_nxt;
      o_press     <= press_nxt;
      o_release   <= release_nxt;
      o_click     <= click_nxt;
      o_long      <= long_nxt;
      o_click_cnt <= click_cnt_nxt;
    end
  end

`ifdef BUTTON_DOUBLE_CLICK_EN
  // Double-click pulse register, only present when the feature is built in.
  always_ff @(posedge i_sys_clk or posedge i_rst) begin
    if (i_rst) begin
      o_double <= 1'b0;
    end else begin
      o_double <= double_nxt;
    end
  end
`else
  assign o_double = 1'b0;
`endif

  // Next-state and next-pulse decode; edges that cannot occur in a state fall through unhandled.
  always_comb begin
    state_nxt     = state;
    timer_nxt     = timer_inc;
    press_nxt     = 1'b0;
    release_nxt   = 1'b0;
    click_nxt     = 1'b0;
    double_nxt    = 1'b0;
    long_nxt      = 1'b0;
    click_cnt_nxt = o_click_cnt;

    case (state)
      IDLE: begin
        timer_nxt = '0;
        if (press_edge) begin
          press_nxt = 1'b1;
          state_nxt = PRESS;
        end
      end

      PRESS: begin
        // A release on the threshold cycle means the key was not "still pressed": short press.
        if (release_edge) begin
          release_nxt = 1'b1;
          timer_nxt   = '0;
`ifdef BUTTON_DOUBLE_CLICK_EN
          state_nxt   = GAP;
`else
          click_nxt     = 1'b1;
          click_cnt_nxt = o_click_cnt + 8'd1;
          state_nxt     = IDLE;
`endif
        end else if (pressed && (timer == LONG_LAST)) begin
          long_nxt  = 1'b1;
          state_nxt = HELD;
        end
      end

      HELD: begin
        // A long press never becomes a click.
        if (release_edge) begin
          release_nxt = 1'b1;
          state_nxt   = IDLE;
        end
      end

`ifdef BUTTON_DOUBLE_CLICK_EN
      GAP: begin
        // Press is tested first so it wins a tie with the gap expiring.
        if (press_edge && (timer <= DOUBLE_LAST)) begin
          press_nxt  = 1'b1;
          double_nxt = 1'b1;
          timer_nxt  = '0;
          state_nxt  = PRESS2;
        end else if (timer >= DOUBLE_LAST) begin
          click_nxt     = 1'b1;
          click_cnt_nxt = o_click_cnt + 8'd1;
          state_nxt     = IDLE;
        end
      end

      PRESS2: begin
        // Second press of a double click: no long detection here.
        if (release_edge) begin
          release_nxt = 1'b1;
          state_nxt   = IDLE;
        end
      end
`endif

      default: begin
        state_nxt = IDLE;
        timer_nxt = '0;
      end
    endcase
  end

endmodule
